// File: rtl/cm_rst_seq.sv
// Purpose: ordered reset sequencer; holds N_CH channel resets, then releases them in index order.
// Latency: ch0 visible released HOLD_CYC cycles after reset/sw reset ends, then one channel per GAP_CYC.
// Backpressure: none; i_sw_rst restarts at any time, i_ch_req pulses are only taken once DONE.
module cm_rst_seq #(
  parameter int              N_CH      = 4,
  parameter int              HOLD_CYC  = 16,
  parameter int              GAP_CYC   = 4,
  parameter logic [N_CH-1:0] CH_ACTIVE = {N_CH{1'b1}},
  localparam int             ST_W      = $clog2(N_CH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_sw_rst,
  input  logic [N_CH-1:0] i_ch_req,
  output logic [N_CH-1:0] o_ch_rst,
  output logic            o_busy,
  output logic            o_done,
  output logic [ST_W-1:0] o_stage
);

  localparam int MAX_CYC   = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CNT_W     = $clog2(MAX_CYC + 1);
  localparam int HOLD_LAST = HOLD_CYC - 1;
  // REL is never entered with GAP_CYC=0, so the clamp only keeps the constant legal.
  localparam int GAP_LAST  = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_REL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [ST_W-1:0]              stage_q, stage_d;
  logic [N_CH-1:0][CNT_W-1:0]   pcnt_q, pcnt_d;
  logic [N_CH-1:0]              ch_rst_q, ch_rst_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  // Next-state: sw reset restarts, HOLD/REL count out releases, DONE runs soft-reset pulses.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stage_d  = stage_q;
    pcnt_d   = pcnt_q;
    ch_rst_d = ch_rst_q;

    if (i_sw_rst) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      stage_d = '0;
      pcnt_d  = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == CNT_W'(HOLD_LAST)) begin
            cnt_d = '0;
            if (N_CH == 1 || GAP_CYC == 0) begin
              stage_d = ST_W'(N_CH);
              state_d = S_DONE;
            end else begin
              stage_d = ST_W'(1);
              state_d = S_REL;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_REL: begin
          if (cnt_q == CNT_W'(GAP_LAST)) begin
            cnt_d   = '0;
            stage_d = stage_q + ST_W'(1);
            if (stage_d == ST_W'(N_CH)) begin
              state_d = S_DONE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          // A request reloads the full pulse length, so a retrigger extends the pulse.
          for (int k = 0; k < N_CH; k++) begin
            if (i_ch_req[k]) begin
              pcnt_d[k] = CNT_W'(HOLD_CYC);
            end else if (pcnt_q[k] != '0) begin
              pcnt_d[k] = pcnt_q[k] - CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
          stage_d = '0;
          pcnt_d  = '0;
        end
      endcase
    end

    // A channel is asserted until the sequence has released it, or while its pulse runs.
    for (int k = 0; k < N_CH; k++) begin
      if ((ST_W'(k) >= stage_d) || (pcnt_d[k] != '0)) begin
        ch_rst_d[k] = CH_ACTIVE[k];
      end else begin
        ch_rst_d[k] = ~CH_ACTIVE[k];
      end
    end

    busy_d = (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; rst forces every channel asserted and restarts in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      stage_q  <= '0;
      pcnt_q   <= '0;
      ch_rst_q <= CH_ACTIVE;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stage_q  <= stage_d;
      pcnt_q   <= pcnt_d;
      ch_rst_q <= ch_rst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_ch_rst = ch_rst_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_stage  = stage_q;

endmodule
